// File: rtl/fnv_pkg.sv
// Shared constants, state encoding and mixing helper for the FNV-1a byte sequencer.
package fnv_pkg;

  localparam logic [31:0] FNV_OFFSET_BASIS = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME        = 32'h01000193;

  // Wide enough for CORE_LATENCY up to 3.
  localparam int unsigned LAT_CNT_W = 2;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HASH_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // XOR a zero-extended byte into the running hash.
  function automatic logic [HASH_W-1:0] fnv_mix(input logic [HASH_W-1:0] h,
                                               input logic [BYTE_W-1:0] b);
    return h ^ {24'h0, b};
  endfunction

endpackage

// File: rtl/fnv_byte_fifo.sv
// Small synchronous byte FIFO; extra pointer bit separates full from empty.
module fnv_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx_c;
  logic [7:0]    mem_q [DEPTH];

  // A flush that coincides with a push leaves exactly that byte in slot 0.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_idx_c = wr_ptr_q[AW-1:0];
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = push ? PW'(1) : '0;
      wr_idx_c = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx_c] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/fnv_byte_sequencer.sv
// Feeds buffered I2C bytes through an external FNV-1a multiply core and latches the digest.
module fnv_byte_sequencer
  import fnv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CORE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msg_start,
  input  logic        msg_end,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [31:0] core_in,
  input  logic [31:0] core_out,
  output logic [31:0] digest,
  output logic        digest_valid,
  output logic        busy,
  output logic        overflow
);

  // WAIT dwells CORE_LATENCY cycles; the counter starts one below that.
  localparam logic [LAT_CNT_W-1:0] LAT_RELOAD =
    (CORE_LATENCY == 0) ? '0 : LAT_CNT_W'(CORE_LATENCY - 1);

  seq_state_t          state_q, state_d;
  logic [HASH_W-1:0]   hash_q, hash_d;
  logic                cap_q, cap_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [HASH_W-1:0]   core_in_q, core_in_d;
  logic [HASH_W-1:0]   digest_q, digest_d;
  logic                digest_valid_q, digest_valid_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic                end_pending_q, end_pending_d;

  logic                fifo_push_c;
  logic                fifo_pop_c;
  logic                fifo_flush_c;
  logic [BYTE_W-1:0]   fifo_dout;
  logic                fifo_empty;
  logic                fifo_full;
  logic [HASH_W-1:0]   hash_eff_c;

  fnv_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_c),
    .pop   (fifo_pop_c),
    .flush (fifo_flush_c),
    .din   (rx_byte),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next-state, hash capture, FIFO control and flag updates.
  // cap_q marks that core_out now holds the product of the last core_in, so the
  // capture can overlap the next pop and sustain one byte per CORE_LATENCY+1 clocks.
  always_comb begin
    state_d        = state_q;
    hash_d         = hash_q;
    cap_d          = cap_q;
    lat_cnt_d      = lat_cnt_q;
    core_in_d      = core_in_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    overflow_d     = overflow_q;
    end_pending_d  = end_pending_q;
    fifo_push_c    = 1'b0;
    fifo_pop_c     = 1'b0;
    fifo_flush_c   = 1'b0;
    hash_eff_c     = cap_q ? core_out : hash_q;

    if (msg_start) begin
      // New message overrides everything; a byte in the same cycle belongs to it.
      state_d        = FEED;
      hash_d         = FNV_OFFSET_BASIS;
      cap_d          = 1'b0;
      lat_cnt_d      = '0;
      overflow_d     = 1'b0;
      end_pending_d  = 1'b0;
      digest_valid_d = 1'b0;
      fifo_flush_c   = 1'b1;
      fifo_push_c    = rx_valid;
    end else begin
      unique case (state_q)
        FEED: begin
          if (cap_q) begin
            hash_d = core_out;
            cap_d  = 1'b0;
          end
          if (!fifo_empty) begin
            fifo_pop_c = 1'b1;
            core_in_d  = fnv_mix(hash_eff_c, fifo_dout);
            if (CORE_LATENCY == 0) begin
              cap_d = 1'b1;
            end else begin
              state_d   = WAIT;
              lat_cnt_d = LAT_RELOAD;
            end
          end else if (end_pending_q) begin
            digest_d       = hash_eff_c;
            digest_valid_d = 1'b1;
            state_d        = DONE;
          end
        end
        WAIT: begin
          if (lat_cnt_q == '0) begin
            state_d = FEED;
            cap_d   = 1'b1;
          end else begin
            lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
          end
        end
        default: begin
        end
      endcase

      // Bytes and end-of-message only count while a message is open.
      if ((state_q == FEED) || (state_q == WAIT)) begin
        if (msg_end) begin
          end_pending_d = 1'b1;
        end
        if (rx_valid) begin
          if (!fifo_full || fifo_pop_c) begin
            fifo_push_c = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
    end

    busy_d = (state_d == FEED) || (state_d == WAIT);
  end

  // State, datapath and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hash_q         <= FNV_OFFSET_BASIS;
      cap_q          <= 1'b0;
      lat_cnt_q      <= '0;
      core_in_q      <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      end_pending_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      hash_q         <= hash_d;
      cap_q          <= cap_d;
      lat_cnt_q      <= lat_cnt_d;
      core_in_q      <= core_in_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      busy_q         <= busy_d;
      overflow_q     <= overflow_d;
      end_pending_q  <= end_pending_d;
    end
  end

  assign core_in      = core_in_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_fnv_byte_sequencer.sv
// Bench for fnv_byte_sequencer: four depth/latency configurations share one stimulus
// stream; each has an FNV core model and a queue-based reference model.
module tb_fnv_byte_sequencer;
  import fnv_pkg::*;

  localparam int unsigned NCFG = 4;

  function automatic int unsigned cfg_depth(input int unsigned i);
    return (i == 3) ? 4 : 8;
  endfunction

  function automatic int unsigned cfg_lat(input int unsigned i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 0;
      default: return 3;
    endcase
  endfunction

  logic       clk;
  logic       reset;
  logic       msg_start;
  logic       msg_end;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       chk_en;

  int n_checks;
  int n_pass;

  logic [7:0] burst [7];
  logic [7:0] foo   [6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input int inst, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL [cfg%0d] %s: got %h expected %h", inst, nm, act, exp);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned D = cfg_depth(g);
    localparam int unsigned L = cfg_lat(g);

    logic [31:0] core_in_o;
    logic [31:0] core_out_i;
    logic [31:0] digest_o;
    logic        dv_o;
    logic        busy_o;
    logic        ovf_o;

    fnv_byte_sequencer #(
      .FIFO_DEPTH   (D),
      .CORE_LATENCY (L)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .msg_start    (msg_start),
      .msg_end      (msg_end),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .core_in      (core_in_o),
      .core_out     (core_out_i),
      .digest       (digest_o),
      .digest_valid (dv_o),
      .busy         (busy_o),
      .overflow     (ovf_o)
    );

    // Core: product appears L clocks after core_in changes.
    if (L == 0) begin : g_comb
      assign core_out_i = core_in_o * FNV_PRIME;
    end else begin : g_pipe
      logic [31:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= core_in_o * FNV_PRIME;
        for (int k = 1; k < int'(L); k++) pipe[k] <= pipe[k-1];
      end
      assign core_out_i = pipe[L-1];
    end

    // Reference model: queue of bytes, a cooldown of L clocks after each pop,
    // and the hash advanced immediately with plain arithmetic.
    logic [7:0]  mq [$];
    logic [31:0] m_hash;
    logic [31:0] m_core_in;
    logic [31:0] m_digest;
    logic        m_active;
    logic        m_dv;
    logic        m_ovf;
    logic        m_endp;
    int          m_cnt;
    bit          m_can;
    logic [7:0]  m_b;

    initial begin
      forever begin
        @(posedge clk);
        if (reset) begin
          mq.delete();
          m_hash = FNV_OFFSET_BASIS; m_core_in = '0; m_digest = '0;
          m_active = 1'b0; m_dv = 1'b0; m_ovf = 1'b0; m_endp = 1'b0; m_cnt = 0;
        end else if (msg_start) begin
          mq.delete();
          m_hash = FNV_OFFSET_BASIS;
          m_active = 1'b1; m_dv = 1'b0; m_ovf = 1'b0; m_endp = 1'b0; m_cnt = 0;
          if (rx_valid) mq.push_back(rx_byte);
        end else if (m_active) begin
          m_can = (m_cnt == 0);
          if (m_cnt > 0) m_cnt--;
          if (m_can && mq.size() > 0) begin
            m_b = mq.pop_front();
            m_core_in = m_hash ^ {24'h0, m_b};
            m_hash = m_core_in * FNV_PRIME;
            m_cnt = int'(L);
          end else if (m_can && m_endp) begin
            m_digest = m_hash;
            m_dv = 1'b1;
            m_active = 1'b0;
          end
          if (rx_valid) begin
            if (mq.size() < int'(D)) mq.push_back(rx_byte);
            else m_ovf = 1'b1;
          end
          if (msg_end) m_endp = 1'b1;
        end
      end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
      forever begin
        @(negedge clk);
        if (chk_en) begin
          check(g, "core_in", core_in_o, m_core_in);
          check(g, "digest", digest_o, m_digest);
          check(g, "digest_valid", 32'(dv_o), 32'(m_dv));
          check(g, "busy", 32'(busy_o), 32'(m_active));
          check(g, "overflow", 32'(ovf_o), 32'(m_ovf));
        end
      end
    end
  end

  logic [NCFG-1:0] dv_vec;
  assign dv_vec = {g_cfg[3].dv_o, g_cfg[2].dv_o, g_cfg[1].dv_o, g_cfg[0].dv_o};

  function automatic logic [31:0] dut_digest(input int i);
    case (i)
      0:       return g_cfg[0].digest_o;
      1:       return g_cfg[1].digest_o;
      2:       return g_cfg[2].digest_o;
      default: return g_cfg[3].digest_o;
    endcase
  endfunction

  function automatic logic [31:0] dut_core_in(input int i);
    case (i)
      0:       return g_cfg[0].core_in_o;
      1:       return g_cfg[1].core_in_o;
      2:       return g_cfg[2].core_in_o;
      default: return g_cfg[3].core_in_o;
    endcase
  endfunction

  // {digest_valid, busy, overflow}
  function automatic logic [31:0] dut_flags(input int i);
    case (i)
      0:       return 32'({g_cfg[0].dv_o, g_cfg[0].busy_o, g_cfg[0].ovf_o});
      1:       return 32'({g_cfg[1].dv_o, g_cfg[1].busy_o, g_cfg[1].ovf_o});
      2:       return 32'({g_cfg[2].dv_o, g_cfg[2].busy_o, g_cfg[2].ovf_o});
      default: return 32'({g_cfg[3].dv_o, g_cfg[3].busy_o, g_cfg[3].ovf_o});
    endcase
  endfunction

  function automatic logic [31:0] ref_burst_hash(input int n);
    logic [31:0] h = FNV_OFFSET_BASIS;
    for (int k = 0; k < n; k++) h = (h ^ {24'h0, burst[k]}) * FNV_PRIME;
    return h;
  endfunction

  // One clock of stimulus; strobes drop back to zero afterwards.
  task automatic cyc(input logic s, input logic e, input logic v, input logic [7:0] b);
    msg_start = s; msg_end = e; rx_valid = v; rx_byte = b;
    @(posedge clk); #1;
    msg_start = 1'b0; msg_end = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dv_vec != '1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (dv_vec != '1) begin
      n_checks++;
      $display("FAIL done_timeout: digest_valid=%b required 1111", dv_vec);
    end
  endtask

  task automatic lit_digest(input string nm, input logic [31:0] exp);
    for (int i = 0; i < int'(NCFG); i++) check(i, nm, dut_digest(i), exp);
  endtask

  initial begin
    int nb;
    bit ended;
    bit last;
    bit e;
    n_checks = 0; n_pass = 0; chk_en = 1'b0;
    msg_start = 1'b0; msg_end = 1'b0; rx_valid = 1'b0; rx_byte = '0;
    reset = 1'b1;
    foo = '{8'h66, 8'h6f, 8'h6f, 8'h62, 8'h61, 8'h72};

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < int'(NCFG); i++) begin
      check(i, "rst_core_in", dut_core_in(i), 32'h0);
      check(i, "rst_digest", dut_digest(i), 32'h0);
      check(i, "rst_flags", dut_flags(i), 32'h0);
    end

    // Empty message.
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    wait_done(50);
    lit_digest("empty_digest", 32'h811C9DC5);
    for (int i = 0; i < int'(NCFG); i++) check(i, "empty_flags", dut_flags(i), 32'h4);

    // Single byte "a"; core_in holds basis^0x61 while waiting on the core.
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h61);
    cyc(0, 1, 0, 8'h00);
    check(0, "wait_core_in", dut_core_in(0), 32'h811C9DA4);
    check(0, "wait_busy", dut_flags(0), 32'h2);
    wait_done(50);
    lit_digest("a_digest", 32'hE40C292C);
    check(0, "model_a", g_cfg[0].m_digest, 32'hE40C292C);

    // "foobar" at one byte per clock, end with the last byte.
    cyc(1, 0, 0, 8'h00);
    for (int k = 0; k < 6; k++) cyc(0, k == 5, 1, foo[k]);
    wait_done(100);
    lit_digest("foobar_digest", 32'hBF9CF968);
    check(1, "model_foobar", g_cfg[1].m_digest, 32'hBF9CF968);

    // Seven back-to-back bytes: the depth-4/latency-3 build drops the seventh.
    for (int k = 0; k < 7; k++) burst[k] = 8'($urandom);
    cyc(1, 0, 0, 8'h00);
    for (int k = 0; k < 7; k++) cyc(0, k == 6, 1, burst[k]);
    wait_done(100);
    check(3, "burst_overflow", 32'(g_cfg[3].ovf_o), 32'h1);
    check(0, "burst_no_overflow", 32'(g_cfg[0].ovf_o), 32'h0);
    check(3, "burst_digest_drop", dut_digest(3), ref_burst_hash(6));
    check(0, "burst_digest_full", dut_digest(0), ref_burst_hash(7));
    cyc(1, 0, 0, 8'h00);
    check(3, "restart_clears_ovf", 32'(g_cfg[3].ovf_o), 32'h0);
    cyc(0, 1, 0, 8'h00);
    wait_done(50);

    // Restart mid-message discards the partial hash.
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h78);
    cyc(0, 0, 1, 8'h79);
    cyc(0, 0, 1, 8'h7a);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 1, 8'h61);
    wait_done(100);
    lit_digest("restart_digest", 32'hE40C292C);

    // Reset while waiting on the core.
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h61);
    cyc(0, 0, 0, 8'h00);
    reset = 1'b1;
    cyc(0, 0, 0, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < int'(NCFG); i++) begin
      check(i, "midrst_core_in", dut_core_in(i), 32'h0);
      check(i, "midrst_digest", dut_digest(i), 32'h0);
      check(i, "midrst_flags", dut_flags(i), 32'h0);
    end
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 1, 8'h61);
    wait_done(50);
    lit_digest("post_rst_digest", 32'hE40C292C);

    // Randomized messages: gaps, bursts, restarts, start+end collisions, idle noise.
    for (int m = 0; m < 250; m++) begin
      nb = $urandom_range(0, 10);
      ended = 1'b0;
      if (nb > 0 && $urandom_range(0, 3) == 0) begin
        cyc(1, 0, 1, 8'($urandom));
        nb--;
      end else begin
        cyc(1, 0, 0, 8'h00);
      end
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) cyc(0, 0, 0, 8'h00);
        last = (k == nb - 1);
        e = last && ($urandom_range(0, 1) == 1);
        cyc(0, e, 1, 8'($urandom));
        if (e) ended = 1'b1;
        if (!last && $urandom_range(0, 19) == 0) cyc(1, 1'($urandom_range(0, 1)), 0, 8'h00);
      end
      if (!ended) cyc(0, 1, 0, 8'h00);
      wait_done(200);
      if ($urandom_range(0, 4) == 0) cyc(0, 1, 1, 8'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
